// File: rtl/adder_amba_pkg.sv
// Shared types for the adder job arbiter: sequencer states and datapath opcodes.
package adder_amba_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_job_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned ID_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             found
);

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      // Offsets 1..N_REQ visit every index once, ending on last_grant itself.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         int unsigned idx;
         idx = (32'(last_grant) + k) % N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_job_arbiter.sv
// Round-robin sequencer sharing one external combinational adder between N_REQ requesters.
module adder_job_arbiter
   import adder_amba_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                    ACLK,
   input  logic                    ARST,
   input  logic [N_REQ-1:0]        i_req_valid,
   output logic [N_REQ-1:0]        o_req_ready,
   input  logic [N_REQ*DATA_W-1:0] i_req_a,
   input  logic [N_REQ*DATA_W-1:0] i_req_b,
   input  logic [N_REQ-1:0]        i_req_op,
   output logic [N_REQ-1:0]        o_rsp_valid,
   input  logic [N_REQ-1:0]        i_rsp_ready,
   output logic [DATA_W-1:0]       o_rsp_data,
   output logic [DATA_W-1:0]       o_dp_busa,
   output logic [DATA_W-1:0]       o_dp_busb,
   output logic                    o_dp_op,
   input  logic [DATA_W-1:0]       i_dp_busr,
   output logic                    o_busy,
   output logic [ID_W-1:0]         o_grant_id,
   output logic [15:0]             o_job_count
);

   state_t              state_q, state_d;
   logic [ID_W-1:0]     last_grant_q;
   logic [DATA_W-1:0]   job_a_q, job_b_q, result_q;
   logic                job_op_q;
   logic [ID_W-1:0]     job_id_q;
   logic [15:0]         job_count_q;

   logic [N_REQ-1:0]    pick_grant;
   logic [ID_W-1:0]     pick_id;
   logic                pick_found;
   logic [DATA_W-1:0]   sel_a, sel_b;
   logic                sel_op;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req        (i_req_valid),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .grant_id   (pick_id),
      .found      (pick_found)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (pick_grant[k]) begin
            sel_a  = i_req_a[k*DATA_W +: DATA_W];
            sel_b  = i_req_b[k*DATA_W +: DATA_W];
            sel_op = i_req_op[k];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      o_req_ready = '0;
      o_rsp_valid = '0;
      unique case (state_q)
         IDLE: begin
            o_req_ready = pick_grant;
            if (pick_found) state_d = EXEC;
         end
         EXEC: state_d = RESP;
         RESP: begin
            o_rsp_valid[job_id_q] = 1'b1;
            if (i_rsp_ready[job_id_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         job_a_q      <= '0;
         job_b_q      <= '0;
         job_op_q     <= 1'b0;
         job_id_q     <= '0;
         result_q     <= '0;
         job_count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_found) begin
            job_a_q  <= sel_a;
            job_b_q  <= sel_b;
            job_op_q <= sel_op;
            job_id_q <= pick_id;
         end
         if (state_q == EXEC) result_q <= i_dp_busr;
         if (state_q == RESP && i_rsp_ready[job_id_q]) begin
            last_grant_q <= job_id_q;
            job_count_q  <= job_count_q + 16'd1;
         end
      end
   end

   assign o_dp_busa   = job_a_q;
   assign o_dp_busb   = job_b_q;
   assign o_dp_op     = job_op_q;
   assign o_rsp_data  = result_q;
   assign o_busy      = (state_q != IDLE);
   assign o_grant_id  = job_id_q;
   assign o_job_count = job_count_q;

endmodule
